tia_write_addr_decode: RTL and testbench

Write-address decoder for the TIA register file. It converts the 6-bit CPU bus address, qualified by the active-low write strobe, into 45 one-hot register-write strobes (VSYNC..CXCLR). The strobes feed the per-register latches in the TIA core. Decoding is registered on the phi2 falling edge, so each strobe is valid for the whole following phi2-low phase and the next phi2-high phase.

---
 rtl/tia_pkg.sv | 56 +++++
 rtl/tia_addr_onehot.sv | 22 ++
 rtl/tia_write_addr_decode.sv | 110 +++++++++++
 tb/tb_tia_write_addr_decode.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_pkg.sv
// Shared TIA definitions: write-register address map and register count.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Optional feature macro used by importers: TIA_WDEC_ANY_EN.
package tia_pkg;

    localparam int TIA_NUM_WREGS = 45;

    // Write-register addresses, 0x00..0x2C. 0x2D..0x3F are unmapped.
    localparam logic [5:0] TIA_VSYNC  = 6'd0;
    localparam logic [5:0] TIA_VBLANK = 6'd1;
    localparam logic [5:0] TIA_WSYNC  = 6'd2;
    localparam logic [5:0] TIA_RSYNC  = 6'd3;
    localparam logic [5:0] TIA_NUSIZ0 = 6'd4;
    localparam logic [5:0] TIA_NUSIZ1 = 6'd5;
    localparam logic [5:0] TIA_COLUP0 = 6'd6;
    localparam logic [5:0] TIA_COLUP1 = 6'd7;
    localparam logic [5:0] TIA_COLUPF = 6'd8;
    localparam logic [5:0] TIA_COLUBK = 6'd9;
    localparam logic [5:0] TIA_CTRLPF = 6'd10;
    localparam logic [5:0] TIA_REFP0  = 6'd11;
    localparam logic [5:0] TIA_REFP1  = 6'd12;
    localparam logic [5:0] TIA_PF0    = 6'd13;
    localparam logic [5:0] TIA_PF1    = 6'd14;
    localparam logic [5:0] TIA_PF2    = 6'd15;
    localparam logic [5:0] TIA_RESP0  = 6'd16;
    localparam logic [5:0] TIA_RESP1  = 6'd17;
    localparam logic [5:0] TIA_RESM0  = 6'd18;
    localparam logic [5:0] TIA_RESM1  = 6'd19;
    localparam logic [5:0] TIA_RESBL  = 6'd20;
    localparam logic [5:0] TIA_AUDC0  = 6'd21;
    localparam logic [5:0] TIA_AUDC1  = 6'd22;
    localparam logic [5:0] TIA_AUDF0  = 6'd23;
    localparam logic [5:0] TIA_AUDF1  = 6'd24;
    localparam logic [5:0] TIA_AUDV0  = 6'd25;
    localparam logic [5:0] TIA_AUDV1  = 6'd26;
    localparam logic [5:0] TIA_GRP0   = 6'd27;
    localparam logic [5:0] TIA_GRP1   = 6'd28;
    localparam logic [5:0] TIA_ENAM0  = 6'd29;
    localparam logic [5:0] TIA_ENAM1  = 6'd30;
    localparam logic [5:0] TIA_ENABL  = 6'd31;
    localparam logic [5:0] TIA_HMP0   = 6'd32;
    localparam logic [5:0] TIA_HMP1   = 6'd33;
    localparam logic [5:0] TIA_HMM0   = 6'd34;
    localparam logic [5:0] TIA_HMM1   = 6'd35;
    localparam logic [5:0] TIA_HMBL   = 6'd36;
    localparam logic [5:0] TIA_VDELP0 = 6'd37;
    localparam logic [5:0] TIA_VDELP1 = 6'd38;
    localparam logic [5:0] TIA_VDELBL = 6'd39;
    localparam logic [5:0] TIA_RESMP0 = 6'd40;
    localparam logic [5:0] TIA_RESMP1 = 6'd41;
    localparam logic [5:0] TIA_HMOVE  = 6'd42;
    localparam logic [5:0] TIA_HMCLR  = 6'd43;
    localparam logic [5:0] TIA_CXCLR  = 6'd44;

endpackage

// File: rtl/tia_addr_onehot.sv
// Combinational 6-bit address to 45-bit one-hot decoder with enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: en (decode enable), addr (6-bit address), onehot (45 strobes, bit i = address i).
module tia_addr_onehot
    import tia_pkg::*;
(
    input  logic                     en,
    input  logic [5:0]               addr,
    output logic [TIA_NUM_WREGS-1:0] onehot
);

    // Addresses above the last register match no bit, so unmapped
    // addresses fall out naturally as an all-zero vector.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < TIA_NUM_WREGS; i++) begin
            onehot[i] = en && (addr == 6'(i));
        end
    end

endmodule

// File: rtl/tia_write_addr_decode.sv
// TIA write-address decoder: registers 45 one-hot write strobes on phi2 falling edge.
// Latency: strobe valid one delta after the sampling falling edge, held one phi2 period.
// Backpressure: none; every falling edge re-decodes, no flow control.
// Ports: phi2 (clock, falling edge), rst_bar (async active-low reset), a[5:0] (address),
//   w_bar (active-low write), 45 named strobe outputs (0x00..0x2C),
//   wr_any (only when TIA_WDEC_ANY_EN is defined: high when any strobe is loaded with 1).
module tia_write_addr_decode
    import tia_pkg::*;
(
    input  logic       phi2,
    input  logic       rst_bar,
    input  logic [5:0] a,
    input  logic       w_bar,
    output logic       vsyn,  vblk,  wsyn,  rsyn,  nsz0,  nsz1,  p0ci,  p1ci,
    output logic       pfci,  bkci,  pfct,  p0rf,  p1rf,  pf0,   pf1,   pf2,
    output logic       p0re,  p1re,  m0re,  m1re,  blre,  auc0,  auc1,  auf0,
    output logic       auf1,  auv0,  auv1,  p0cr,  p1cr,  m0en,  m1en,  blen,
    output logic       p0hm,  p1hm,  m0hm,  m1hm,  blhm,  p0vd,  p1vd,  blvd,
    output logic       m0pre, m1pre, hmove, hmclr, cxclr
`ifdef TIA_WDEC_ANY_EN
    ,
    output logic       wr_any
`endif
);

    logic [TIA_NUM_WREGS-1:0] strobe_d;
    logic [TIA_NUM_WREGS-1:0] strobe_q;

    tia_addr_onehot u_onehot (
        .en     (~w_bar),
        .addr   (a),
        .onehot (strobe_d)
    );

    // State changes on the phi2 falling edge so strobes span the following
    // low phase and the next high phase.
    always_ff @(negedge phi2 or negedge rst_bar) begin
        if (!rst_bar) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

`ifdef TIA_WDEC_ANY_EN
    logic wr_any_d;
    logic wr_any_q;

    always_comb begin
        wr_any_d = |strobe_d;
    end

    always_ff @(negedge phi2 or negedge rst_bar) begin
        if (!rst_bar) begin
            wr_any_q <= 1'b0;
        end else begin
            wr_any_q <= wr_any_d;
        end
    end

    assign wr_any = wr_any_q;
`endif

    assign vsyn  = strobe_q[TIA_VSYNC];
    assign vblk  = strobe_q[TIA_VBLANK];
    assign wsyn  = strobe_q[TIA_WSYNC];
    assign rsyn  = strobe_q[TIA_RSYNC];
    assign nsz0  = strobe_q[TIA_NUSIZ0];
    assign nsz1  = strobe_q[TIA_NUSIZ1];
    assign p0ci  = strobe_q[TIA_COLUP0];
    assign p1ci  = strobe_q[TIA_COLUP1];
    assign pfci  = strobe_q[TIA_COLUPF];
    assign bkci  = strobe_q[TIA_COLUBK];
    assign pfct  = strobe_q[TIA_CTRLPF];
    assign p0rf  = strobe_q[TIA_REFP0];
    assign p1rf  = strobe_q[TIA_REFP1];
    assign pf0   = strobe_q[TIA_PF0];
    assign pf1   = strobe_q[TIA_PF1];
    assign pf2   = strobe_q[TIA_PF2];
    assign p0re  = strobe_q[TIA_RESP0];
    assign p1re  = strobe_q[TIA_RESP1];
    assign m0re  = strobe_q[TIA_RESM0];
    assign m1re  = strobe_q[TIA_RESM1];
    assign blre  = strobe_q[TIA_RESBL];
    assign auc0  = strobe_q[TIA_AUDC0];
    assign auc1  = strobe_q[TIA_AUDC1];
    assign auf0  = strobe_q[TIA_AUDF0];
    assign auf1  = strobe_q[TIA_AUDF1];
    assign auv0  = strobe_q[TIA_AUDV0];
    assign auv1  = strobe_q[TIA_AUDV1];
    assign p0cr  = strobe_q[TIA_GRP0];
    assign p1cr  = strobe_q[TIA_GRP1];
    assign m0en  = strobe_q[TIA_ENAM0];
    assign m1en  = strobe_q[TIA_ENAM1];
    assign blen  = strobe_q[TIA_ENABL];
    assign p0hm  = strobe_q[TIA_HMP0];
    assign p1hm  = strobe_q[TIA_HMP1];
    assign m0hm  = strobe_q[TIA_HMM0];
    assign m1hm  = strobe_q[TIA_HMM1];
    assign blhm  = strobe_q[TIA_HMBL];
    assign p0vd  = strobe_q[TIA_VDELP0];
    assign p1vd  = strobe_q[TIA_VDELP1];
    assign blvd  = strobe_q[TIA_VDELBL];
    assign m0pre = strobe_q[TIA_RESMP0];
    assign m1pre = strobe_q[TIA_RESMP1];
    assign hmove = strobe_q[TIA_HMOVE];
    assign hmclr = strobe_q[TIA_HMCLR];
    assign cxclr = strobe_q[TIA_CXCLR];

endmodule

// File: tb/tb_tia_write_addr_decode.sv
// Self-checking bench for tia_write_addr_decode.
// Latency: strobes checked 1 time unit after each phi2 falling edge.
// Backpressure: n/a. Optional TIA_WDEC_ANY_EN adds wr_any checks.
module tb_tia_write_addr_decode;

    logic       phi2 = 1'b0;
    logic       rst_bar = 1'b1;
    logic [5:0] a = 6'd0;
    logic       w_bar = 1'b1;

    logic vsyn, vblk, wsyn, rsyn, nsz0, nsz1, p0ci, p1ci;
    logic pfci, bkci, pfct, p0rf, p1rf, pf0, pf1, pf2;
    logic p0re, p1re, m0re, m1re, blre, auc0, auc1, auf0;
    logic auf1, auv0, auv1, p0cr, p1cr, m0en, m1en, blen;
    logic p0hm, p1hm, m0hm, m1hm, blhm, p0vd, p1vd, blvd;
    logic m0pre, m1pre, hmove, hmclr, cxclr;
`ifdef TIA_WDEC_ANY_EN
    logic wr_any;
`endif

    int checks = 0;
    int errors = 0;

    logic [44:0] out_vec;
    assign out_vec = {cxclr, hmclr, hmove, m1pre, m0pre, blvd, p1vd, p0vd,
                      blhm, m1hm, m0hm, p1hm, p0hm, blen, m1en, m0en,
                      p1cr, p0cr, auv1, auv0, auf1, auf0, auc1, auc0,
                      blre, m1re, m0re, p1re, p0re, pf2, pf1, pf0,
                      p1rf, p0rf, pfct, bkci, pfci, p1ci, p0ci, nsz1,
                      nsz0, rsyn, wsyn, vblk, vsyn};

    tia_write_addr_decode dut (
        .phi2(phi2), .rst_bar(rst_bar), .a(a), .w_bar(w_bar),
        .vsyn(vsyn), .vblk(vblk), .wsyn(wsyn), .rsyn(rsyn), .nsz0(nsz0), .nsz1(nsz1),
        .p0ci(p0ci), .p1ci(p1ci), .pfci(pfci), .bkci(bkci), .pfct(pfct), .p0rf(p0rf),
        .p1rf(p1rf), .pf0(pf0), .pf1(pf1), .pf2(pf2),
        .p0re(p0re), .p1re(p1re), .m0re(m0re), .m1re(m1re), .blre(blre), .auc0(auc0),
        .auc1(auc1), .auf0(auf0), .auf1(auf1), .auv0(auv0), .auv1(auv1), .p0cr(p0cr),
        .p1cr(p1cr), .m0en(m0en), .m1en(m1en), .blen(blen),
        .p0hm(p0hm), .p1hm(p1hm), .m0hm(m0hm), .m1hm(m1hm), .blhm(blhm), .p0vd(p0vd),
        .p1vd(p1vd), .blvd(blvd), .m0pre(m0pre), .m1pre(m1pre), .hmove(hmove),
        .hmclr(hmclr), .cxclr(cxclr)
`ifdef TIA_WDEC_ANY_EN
        , .wr_any(wr_any)
`endif
    );

    always #5 phi2 = ~phi2;

    // Reference: a write to a mapped address lights exactly bit a.
    function automatic logic [44:0] model(input logic [5:0] addr, input logic wb);
        if (!wb && addr < 6'd45) return 45'd1 << addr;
        return 45'd0;
    endfunction

    // Present a new bus cycle just after the rising edge.
    task automatic drive(input logic [5:0] addr, input logic wb);
        @(posedge phi2);
        #1;
        a = addr;
        w_bar = wb;
    endtask

    task automatic test_reset;
        logic [44:0] exp;
        rst_bar = 1'b1;
        #2;
        rst_bar = 1'b0;
        a = 6'd0;
        w_bar = 1'b0;
        #1;
        checks++;
        if (out_vec !== 45'd0) begin
            errors++;
            $display("FAIL reset_initial: got %h want %h", out_vec, 45'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge phi2);
            #1;
            checks++;
            if (out_vec !== 45'd0) begin
                errors++;
                $display("FAIL reset_held cyc%0d: got %h want %h", i, out_vec, 45'd0);
            end
        end
        @(posedge phi2);
        #1;
        rst_bar = 1'b1;
        @(negedge phi2);
        #1;
        exp = model(6'd0, 1'b0);
        checks++;
        if (out_vec !== exp || vsyn !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got %h want %h (vsyn=%b)", out_vec, exp, vsyn);
        end
    endtask

    task automatic test_sweep;
        logic [44:0] exp;
        for (int i = 0; i < 45; i++) begin
            drive(6'(i), 1'b0);
            @(negedge phi2);
            #1;
            exp = model(6'(i), 1'b0);
            checks++;
            if (out_vec !== exp || $countones(out_vec) != 1) begin
                errors++;
                $display("FAIL sweep a=%0d: got %h want %h", i, out_vec, exp);
            end
`ifdef TIA_WDEC_ANY_EN
            checks++;
            if (wr_any !== 1'b1) begin
                errors++;
                $display("FAIL sweep_any a=%0d: got %b want 1", i, wr_any);
            end
`endif
        end
        // Spot-check named strobes against their fixed addresses.
        drive(6'd13, 1'b0); @(negedge phi2); #1;
        checks++;
        if (pf0 !== 1'b1) begin errors++; $display("FAIL named_pf0: got %b want 1", pf0); end
        drive(6'd42, 1'b0); @(negedge phi2); #1;
        checks++;
        if (hmove !== 1'b1) begin errors++; $display("FAIL named_hmove: got %b want 1", hmove); end
        drive(6'd44, 1'b0); @(negedge phi2); #1;
        checks++;
        if (cxclr !== 1'b1) begin errors++; $display("FAIL named_cxclr: got %b want 1", cxclr); end
    endtask

    task automatic test_unmapped;
        logic [5:0] addrs [3] = '{6'd45, 6'd50, 6'd63};
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 1'b0);
            @(negedge phi2);
            #1;
            checks++;
            if (out_vec !== 45'd0) begin
                errors++;
                $display("FAIL unmapped a=%0d: got %h want 0", addrs[i], out_vec);
            end
`ifdef TIA_WDEC_ANY_EN
            checks++;
            if (wr_any !== 1'b0) begin
                errors++;
                $display("FAIL unmapped_any a=%0d: got %b want 0", addrs[i], wr_any);
            end
`endif
        end
    endtask

    task automatic test_read_cycle;
        drive(6'h2A, 1'b1);
        @(negedge phi2);
        #1;
        checks++;
        if (out_vec !== 45'd0 || hmove !== 1'b0) begin
            errors++;
            $display("FAIL read_cycle: got %h want 0", out_vec);
        end
        drive(6'h2A, 1'b0);
        @(negedge phi2);
        #1;
        checks++;
        if (hmove !== 1'b1 || out_vec !== model(6'h2A, 1'b0)) begin
            errors++;
            $display("FAIL read_to_write: got %h want %h", out_vec, model(6'h2A, 1'b0));
        end
    endtask

    task automatic test_hold;
        drive(6'h03, 1'b0);
        @(negedge phi2);
        #1;
        checks++;
        if (rsyn !== 1'b1) begin errors++; $display("FAIL hold_rsyn_set: got %b want 1", rsyn); end
        @(posedge phi2);
        #1;
        a = 6'h04;
        #1;
        checks++;
        if (rsyn !== 1'b1 || nsz0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_high_phase: got rsyn=%b nsz0=%b want 1 0", rsyn, nsz0);
        end
        @(negedge phi2);
        #1;
        checks++;
        if (nsz0 !== 1'b1 || rsyn !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_edge: got rsyn=%b nsz0=%b want 0 1", rsyn, nsz0);
        end
    endtask

    task automatic test_async_reset;
        drive(6'h0F, 1'b0);
        @(negedge phi2);
        #1;
        checks++;
        if (pf2 !== 1'b1) begin errors++; $display("FAIL areset_pf2_set: got %b want 1", pf2); end
        @(posedge phi2);
        #1;
        rst_bar = 1'b0;
        #1;
        checks++;
        if (pf2 !== 1'b0 || out_vec !== 45'd0) begin
            errors++;
            $display("FAIL areset_drop: got %h want 0", out_vec);
        end
        rst_bar = 1'b1;
        #1;
        checks++;
        if (out_vec !== 45'd0) begin
            errors++;
            $display("FAIL areset_after_release: got %h want 0", out_vec);
        end
        @(negedge phi2);
        #1;
        checks++;
        if (pf2 !== 1'b1) begin
            errors++;
            $display("FAIL areset_redecode: got %b want 1", pf2);
        end
    endtask

    task automatic test_random;
        logic [5:0]  ra;
        logic        rw;
        logic [44:0] exp;
        for (int i = 0; i < 300; i++) begin
            ra = 6'($urandom_range(0, 63));
            rw = ($urandom_range(0, 3) == 0);
            drive(ra, rw);
            // Glitch the bus during the high phase; only the value at the fall counts.
            if ($urandom_range(0, 1) == 1) begin
                #1;
                a = 6'($urandom_range(0, 63));
                #1;
                a = ra;
            end
            @(negedge phi2);
            #1;
            exp = model(ra, rw);
            checks++;
            if (out_vec !== exp) begin
                errors++;
                $display("FAIL random a=%0d w_bar=%b: got %h want %h", ra, rw, out_vec, exp);
            end
`ifdef TIA_WDEC_ANY_EN
            checks++;
            if (wr_any !== (exp != 45'd0)) begin
                errors++;
                $display("FAIL random_any a=%0d w_bar=%b: got %b want %b", ra, rw, wr_any, exp != 45'd0);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_unmapped();
        test_read_cycle();
        test_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
